// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC and drives a single-outstanding req/addr_ok/data_ok bus.
// Optional fetch wait-cycle counter is enabled by defining PC_FETCH_PERF_CNT_EN.
module pc_fetch_ctrl #(
    parameter int                WIDTH    = 32,
    parameter logic [WIDTH-1:0]  RESET_PC = 32'hBFC00000,
    parameter logic [WIDTH-1:0]  EXC_VEC  = 32'hBFC00380
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             stall_i,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             exception,
    input  logic             eret,
    input  logic [WIDTH-1:0] epc,
    output logic             inst_req,
    output logic [WIDTH-1:0] inst_addr,
    input  logic             inst_addr_ok,
    input  logic             inst_data_ok,
    input  logic [WIDTH-1:0] inst_rdata,
    output logic             if_valid,
    output logic [WIDTH-1:0] if_inst,
    output logic [WIDTH-1:0] if_pc,
    output logic [31:0]      perf_wait_cnt
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_VALID} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] if_inst_q, if_pc_q;
    logic             kill_q, kill_d;
    logic             cap;
    logic             redirect;
    logic [WIDTH-1:0] redir_pc;

    // Exception has priority over eret; both override branch and stall.
    assign redirect = exception | eret;
    assign redir_pc = exception ? EXC_VEC : epc;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            kill_q    <= 1'b0;
            if_inst_q <= '0;
            if_pc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            if (cap) begin
                if_inst_q <= inst_rdata;
                if_pc_q   <= pc_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        kill_d  = kill_q;
        cap     = 1'b0;
        case (state_q)
            S_REQ: begin
                if (redirect) pc_d = redir_pc;
                if (inst_addr_ok) begin
                    state_d = S_WAIT;
                    // The accepted address is now stale; drop its response.
                    if (redirect) kill_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (inst_data_ok) begin
                    state_d = S_REQ;
                    kill_d  = 1'b0;
                    if (redirect) begin
                        pc_d = redir_pc;
                    end else if (!kill_q) begin
                        cap     = 1'b1;
                        state_d = S_VALID;
                    end
                end else if (redirect) begin
                    pc_d   = redir_pc;
                    kill_d = 1'b1;
                end
            end
            S_VALID: begin
                if (redirect) begin
                    pc_d    = redir_pc;
                    state_d = S_REQ;
                end else if (!stall_i) begin
                    pc_d    = branch_taken ? branch_target : pc_q + WIDTH'(4);
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // Gate with resetn so no request is visible while reset is held.
    assign inst_req  = (state_q == S_REQ) && resetn;
    assign inst_addr = pc_q;
    assign if_valid  = (state_q == S_VALID);
    assign if_inst   = if_inst_q;
    assign if_pc     = if_pc_q;

`ifdef PC_FETCH_PERF_CNT_EN
    logic [31:0] perf_q;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            perf_q <= '0;
        else if (state_q == S_REQ || state_q == S_WAIT)
            perf_q <= perf_q + 32'd1;
    end
    assign perf_wait_cnt = perf_q;
`else
    assign perf_wait_cnt = '0;
`endif

endmodule
